// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit_pkg : next-PC select codes, vector defaults, fetch FSM states
// Revision 1.0
// ============================================================================
package pc_fetch_unit_pkg;

  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_BR  = 3'd1;
  localparam logic [2:0] PC_J   = 3'd2;
  localparam logic [2:0] PC_JR  = 3'd3;
  localparam logic [2:0] PC_IRQ = 3'd4;
  localparam logic [2:0] PC_EXC = 3'd5;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit_if : instruction-memory fetch handshake
// Revision 1.0
// ============================================================================
interface pc_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, output imem_req, input imem_ready, input imem_rdata);
  modport slave  (input imem_addr, input imem_req, output imem_ready, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_next_pc_calc.sv
`default_nettype none
// ============================================================================
// next_pc_calc : combinational next-PC mux with supervisor-bit policing
// Revision 1.0
// ============================================================================
module next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
  input  logic [31:0] pc_i,
  input  logic [2:0]  pcsrc_i,
  input  logic        branch_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] target26_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + 32'd4;

  always_comb begin
    next_pc_o = pc_plus4_o;
    case (pcsrc_i)
      PC_SEQ: next_pc_o = pc_plus4_o;
      PC_BR: begin
        if (branch_taken_i) next_pc_o = pc_plus4_o + br_offset(imm16_i);
        next_pc_o[31] = pc_i[31];
      end
      PC_J: begin
        next_pc_o     = {pc_plus4_o[31:28], target26_i, 2'b00};
        next_pc_o[31] = pc_i[31];
      end
      PC_JR: begin
        // Only kernel code may choose the mode bit through a register jump.
        next_pc_o = jr_addr_i & 32'hFFFF_FFFC;
        if (!pc_i[31]) next_pc_o[31] = 1'b0;
      end
      PC_IRQ:  next_pc_o = (IRQ_VEC | 32'h8000_0000) & 32'hFFFF_FFFC;
      default: next_pc_o = (EXC_VEC | 32'h8000_0000) & 32'hFFFF_FFFC;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : PC, instruction register, EPC and interrupt latch with fetch FSM
// Revision 1.0
// ============================================================================
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IRQ_VEC  = DEF_IRQ_VEC,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            instruct,
  output logic                   instr_valid,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   irq_req,
  input  logic                   irq,
  input  logic [2:0]             PCSrc,
  input  logic                   branch_taken,
  input  logic [15:0]            imm16,
  input  logic [25:0]            target26,
  input  logic [31:0]            jr_addr,
  input  logic                   stall,
  output logic [31:0]            epc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  epc_q, epc_d;
  logic         irq_pending_q, irq_pending_d;
  logic [31:0]  next_pc;

  next_pc_calc #(
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) u_next_pc_calc (
    .pc_i           (pc_q),
    .pcsrc_i        (PCSrc),
    .branch_taken_i (branch_taken),
    .imm16_i        (imm16),
    .target26_i     (target26),
    .jr_addr_i      (jr_addr),
    .next_pc_o      (next_pc),
    .pc_plus4_o     (pc_plus4)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= 32'd0;
      epc_q         <= 32'd0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      epc_q         <= epc_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    epc_d         = epc_q;
    irq_pending_d = irq_pending_q | (irq & ~pc_q[31]);
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem.imem_ready) begin
          ir_d    = imem.imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = ST_REQ;
          // Interrupt return re-executes the interrupted instruction.
          if (PCSrc == PC_IRQ) begin
            epc_d         = pc_q;
            irq_pending_d = 1'b0;
          end else if (PCSrc >= PC_EXC) begin
            epc_d = pc_plus4;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == ST_EXEC);
  assign instruct       = ir_q;
  assign pc             = pc_q;
  assign epc            = epc_q;
  assign irq_req        = irq_pending_q & ~pc_q[31];

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_pc_fetch_unit : scoreboard bench for the fetch stage
// Revision 1.0
// ============================================================================
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq = 1'b0;
  logic        branch_taken = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] target26 = 26'd0;
  logic [31:0] jr_addr = 32'd0;
  logic [31:0] instruct, pc, pc_plus4, epc;
  logic        instr_valid, irq_req;

  pc_fetch_unit_if imem_bus();

  int          tests = 0;
  int          fails = 0;
  logic [31:0] addr_q[$];
  logic [31:0] word_q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_epc = 32'd0;
  logic [31:0] exp_v;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_bus.master),
    .instruct     (instruct),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .irq_req      (irq_req),
    .irq          (irq),
    .PCSrc        (PCSrc),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .jr_addr      (jr_addr),
    .stall        (stall),
    .epc          (epc)
  );

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [2:0] src,
                                             input logic bt, input logic [15:0] imm,
                                             input logic [25:0] tgt, input logic [31:0] jr);
    logic [31:0] seq, r;
    seq = cur + 32'd4;
    r   = seq;
    if (src == 3'd1) begin
      if (bt) r = seq + ({{16{imm[15]}}, imm} << 2);
      r = {cur[31], r[30:0]};
    end else if (src == 3'd2) begin
      r = {cur[31], seq[30:28], tgt, 2'b00};
    end else if (src == 3'd3) begin
      r = {cur[31] & jr[31], jr[30:2], 2'b00};
    end else if (src == 3'd4) begin
      r = 32'h8000_0004;
    end else if (src >= 3'd5) begin
      r = 32'h8000_0008;
    end
    return r;
  endfunction

  // Scoreboard monitor: fetch addresses and latched words leave the queues here.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_bus.imem_req && imem_bus.imem_ready) begin
        tests++;
        if (addr_q.size() == 0) begin
          fails++;
          $display("FAIL fetch_addr: got unexpected fetch at %h, required none", imem_bus.imem_addr);
        end else begin
          exp_v = addr_q.pop_front();
          if (imem_bus.imem_addr !== exp_v) begin
            fails++;
            $display("FAIL fetch_addr: got %h, required %h", imem_bus.imem_addr, exp_v);
          end
        end
      end
      if (instr_valid && !prev_valid) begin
        tests++;
        if (word_q.size() == 0) begin
          fails++;
          $display("FAIL instruct: got unexpected valid word %h, required none", instruct);
        end else begin
          exp_v = word_q.pop_front();
          if (instruct !== exp_v) begin
            fails++;
            $display("FAIL instruct: got %h, required %h", instruct, exp_v);
          end
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_bus.imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_bus.imem_req) begin
      tests++; fails++;
      $display("FAIL req_timeout: got imem_req=%b after %0d cycles, required 1", imem_bus.imem_req, n);
    end
  endtask

  task automatic fetch(input int delay, input logic [31:0] word);
    wait_req();
    repeat (delay) begin @(posedge clk); #1; end
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = word;
    word_q.push_back(word);
    @(posedge clk); #1;
    imem_bus.imem_ready = 1'b0;
  endtask

  task automatic commit(input logic [2:0] src, input logic bt, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] jr);
    logic [31:0] nxt;
    PCSrc = src; branch_taken = bt; imm16 = imm; target26 = tgt; jr_addr = jr;
    stall = 1'b0;
    nxt = model_next(m_pc, src, bt, imm, tgt, jr);
    if (src == 3'd4) m_epc = m_pc;
    else if (src >= 3'd5) m_epc = m_pc + 32'd4;
    m_pc = nxt;
    addr_q.push_back(nxt);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b, required 0", imem_bus.imem_req); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    tests++; if (pc !== RST_PC) begin fails++; $display("FAIL rst_pc: got %h, required %h", pc, RST_PC); end
    tests++; if (imem_bus.imem_addr !== RST_PC) begin fails++; $display("FAIL rst_addr: got %h, required %h", imem_bus.imem_addr, RST_PC); end
    tests++; if (instruct !== 32'd0) begin fails++; $display("FAIL rst_ir: got %h, required 0", instruct); end
    tests++; if (epc !== 32'd0) begin fails++; $display("FAIL rst_epc: got %h, required 0", epc); end
    tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b, required 0", irq_req); end
    tests++; if (pc_plus4 !== 32'h8000_0004) begin fails++; $display("FAIL rst_pc4: got %h, required 80000004", pc_plus4); end
    @(negedge clk); reset = 1'b1;
    m_pc = RST_PC; m_epc = 32'd0;
    addr_q.push_back(RST_PC);
    #1;
    tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL idle_req: got %b, required 0", imem_bus.imem_req); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      fetch(0, 32'h1000_0000 + 32'(i));
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL seq_valid_hi: got %b, required 1", instr_valid); end
      commit(PC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL seq_valid_lo: got %b, required 0", instr_valid); end
    end
  endtask

  task automatic test_branch();
    fetch(0, 32'h2000_0001);
    commit(PC_JR, 1'b0, 16'd0, 26'd0, 32'h0000_0010);
    fetch(0, 32'h2000_0002);
    tests++; if (pc !== 32'h0000_0010) begin fails++; $display("FAIL kjr_pc: got %h, required 00000010", pc); end
    commit(PC_BR, 1'b1, 16'hFFFC, 26'd0, 32'd0);
    tests++; if (pc !== 32'h0000_0004) begin fails++; $display("FAIL br_taken: got %h, required 00000004", pc); end
    fetch(1, 32'h2000_0003);
    commit(PC_JR, 1'b0, 16'd0, 26'd0, 32'h0000_0010);
    fetch(0, 32'h2000_0004);
    commit(PC_BR, 1'b0, 16'hFFFC, 26'd0, 32'd0);
    tests++; if (pc !== 32'h0000_0014) begin fails++; $display("FAIL br_not_taken: got %h, required 00000014", pc); end
  endtask

  task automatic test_jump();
    fetch(0, 32'h3000_0001);
    commit(PC_JR, 1'b0, 16'd0, 26'd0, 32'h0040_0000);
    fetch(0, 32'h3000_0002);
    commit(PC_J, 1'b0, 16'd0, 26'h0000100, 32'd0);
    tests++; if (pc !== 32'h0000_0400) begin fails++; $display("FAIL j_target: got %h, required 00000400", pc); end
    fetch(0, 32'h3000_0003);
    commit(PC_JR, 1'b0, 16'd0, 26'd0, 32'h8000_0123);
    tests++; if (pc !== 32'h0000_0120) begin fails++; $display("FAIL ujr_mask: got %h, required 00000120", pc); end
  endtask

  task automatic test_irq_exc();
    fetch(0, 32'h4000_0001);
    commit(PC_JR, 1'b0, 16'd0, 26'd0, 32'h0000_0020);
    irq = 1'b1;
    @(posedge clk); #1;
    irq = 1'b0;
    tests++; if (irq_req !== 1'b1) begin fails++; $display("FAIL irq_set: got %b, required 1", irq_req); end
    fetch(0, 32'h4000_0002);
    tests++; if (irq_req !== 1'b1) begin fails++; $display("FAIL irq_hold: got %b, required 1", irq_req); end
    irq = 1'b1;
    commit(PC_IRQ, 1'b0, 16'd0, 26'd0, 32'd0);
    irq = 1'b0;
    tests++; if (pc !== 32'h8000_0004) begin fails++; $display("FAIL irq_vec: got %h, required 80000004", pc); end
    tests++; if (epc !== 32'h0000_0020) begin fails++; $display("FAIL irq_epc: got %h, required 00000020", epc); end
    tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL irq_clr: got %b, required 0", irq_req); end
    fetch(0, 32'h4000_0003);
    commit(3'd6, 1'b0, 16'd0, 26'd0, 32'd0);
    tests++; if (pc !== 32'h8000_0008) begin fails++; $display("FAIL exc_vec: got %h, required 80000008", pc); end
    tests++; if (epc !== m_epc) begin fails++; $display("FAIL exc_epc: got %h, required %h", epc, m_epc); end
    fetch(0, 32'h4000_0004);
    commit(PC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
    tests++; if (epc !== 32'h8000_0008) begin fails++; $display("FAIL epc_hold: got %h, required 80000008", epc); end
    fetch(0, 32'h4000_0005);
    commit(PC_JR, 1'b0, 16'd0, 26'd0, 32'h0000_0020);
    tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL irq_clear_wins: got %b, required 0", irq_req); end
  endtask

  task automatic test_stall();
    logic [31:0] w = 32'h5A5A_0001;
    wait_req();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (imem_bus.imem_addr !== m_pc || imem_bus.imem_req !== 1'b1) begin
        fails++; $display("FAIL wait_addr: got %h req=%b, required %h req=1", imem_bus.imem_addr, imem_bus.imem_req, m_pc);
      end
      @(posedge clk); #1;
    end
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = w;
    word_q.push_back(w);
    @(posedge clk); #1;
    stall = 1'b1;
    imem_bus.imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (instruct !== w || pc !== m_pc || instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
        fails++; $display("FAIL stall_hold: got ir=%h pc=%h v=%b req=%b, required ir=%h pc=%h v=1 req=0",
                          instruct, pc, instr_valid, imem_bus.imem_req, w, m_pc);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    imem_bus.imem_ready = 1'b0;
    commit(PC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
    tests++; if (pc !== 32'h0000_0024) begin fails++; $display("FAIL stall_commit: got %h, required 00000024", pc); end
  endtask

  task automatic test_reset_mid_req();
    wait_req();
    imem_bus.imem_ready = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    #2 reset = 1'b0;
    #1;
    tests++;
    if (imem_bus.imem_req !== 1'b0 || pc !== RST_PC || instr_valid !== 1'b0 || imem_bus.imem_addr !== RST_PC) begin
      fails++; $display("FAIL async_rst: got req=%b pc=%h v=%b addr=%h, required req=0 pc=%h v=0 addr=%h",
                        imem_bus.imem_req, pc, instr_valid, imem_bus.imem_addr, RST_PC, RST_PC);
    end
    @(posedge clk); #1;
    tests++; if (instruct !== 32'd0) begin fails++; $display("FAIL rst_ir_ignore: got %h, required 0", instruct); end
    tests++; if (epc !== 32'd0) begin fails++; $display("FAIL rst_epc2: got %h, required 0", epc); end
    imem_bus.imem_ready = 1'b0;
    addr_q.delete(); word_q.delete();
    m_pc = RST_PC; m_epc = 32'd0;
    @(negedge clk); reset = 1'b1;
    addr_q.push_back(RST_PC);
    fetch(0, 32'h6000_0001);
    commit(PC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
    fetch(2, 32'h6000_0002);
    @(negedge clk); #1;
    tests++;
    if (addr_q.size() != 0 || word_q.size() != 0) begin
      fails++; $display("FAIL sb_drain: got addr=%0d word=%0d pending, required 0 0", addr_q.size(), word_q.size());
    end
  endtask

  initial begin
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_irq_exc();
    test_stall();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200us");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode/control unit.
- Holds the program counter and fetches one instruction word per instruction from instruction memory over a req/ready handshake.
- Presents the word as `instruct` to control, together with an interrupt-request qualifier.
- Consumes control's PCSrc plus datapath branch/jump operands to compute the next PC, including the supervisor bit PC[31], interrupt/exception vectors and the EPC.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset (kernel mode)
IRQ_VEC, 32'h8000_0004, interrupt handler entry
EXC_VEC, 32'h8000_0008, exception / undefined-instruction entry

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
imem_addr  out  32  fetch address, equal to pc while imem_req=1
imem_req  out  1  fetch request
imem_ready  in  1  read data valid this cycle
imem_rdata  in  32  instruction word
instruct  out  32  latched instruction register, to control
instr_valid  out  1  instruct is current and executing
pc  out  32  address of current instruction
pc_plus4  out  32  pc+4, for jal/jalr link
irq_req  out  1  pending interrupt while in user mode, to control IRQ input
PCSrc  in  3  next-PC select from control
branch_taken  in  1  ALU branch condition result
imm16  in  16  branch offset field
target26  in  26  jump target field
jr_addr  in  32  register value for jr/jalr
stall  in  1  hold current instruction (datapath busy)
epc  out  32  saved return address for interrupt/exception

Behaviour:
- FSM states IDLE, REQ, EXEC.
  - IDLE: entered on reset; the next clock goes to REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready=1, ir<=imem_rdata and go to EXEC. Waits indefinitely otherwise.
  - EXEC: instr_valid=1.
    - If stall=1, stay in EXEC with pc, ir and epc held.
    - If stall=0, commit: pc<=next_pc, go to REQ.
  - Minimum 2 cycles per instruction (ready in first REQ cycle).
- Reset values: pc=RESET_PC, ir=0 (nop), epc=0, irq_pending=0, state=IDLE, imem_req=0, instr_valid=0. imem_addr=pc.
- Reset asserted mid-REQ or mid-EXEC: outputs return to reset values immediately (asynchronous); any in-flight imem_ready is ignored.
- imem_ready outside REQ is ignored.
- next_pc by PCSrc; all adds are mod 2^32, wrap allowed:
  - 0: pc+4
  - 1: branch_taken ? pc+4+(sign_extend(imm16)<<2) : pc+4
  - 2: {pc_plus4[31:28], target26, 2'b00}
  - 3: jr_addr with bits [1:0] forced to 00
  - 4: IRQ_VEC
  - 5, 6, 7: EXC_VEC
- Supervisor bit:
  - For PCSrc 1 and 2, next_pc[31] is forced to current pc[31].
  - For PCSrc 3, if pc[31]=0 then next_pc[31] is forced to 0 (user code cannot enter kernel via jr). If pc[31]=1, jr_addr[31] is taken as-is, so the kernel returns to user via jr.
  - PCSrc 4/5 always set bit 31.
- Interrupt:
  - irq_pending is set on any clock where IRQ=1 and pc[31]=0.
  - irq_req = irq_pending & ~pc[31], combinational.
  - On EXEC commit with PCSrc=4: epc<=pc (interrupted instruction is re-executed) and irq_pending<=0.
  - If IRQ=1 on that same commit cycle, clear wins; re-set cannot occur afterwards because pc[31]=1.
- Exception: on EXEC commit with PCSrc=5..7, epc<=pc+4.
- epc changes only on those commits.
- pc[1:0] is always 00.

Decomposition:
- Shared package (cpu_defs): PCSrc encodings PC_SEQ=0, PC_BR=1, PC_J=2, PC_JR=3, PC_IRQ=4, PC_EXC=5; vector constants; FSM state encoding.
- One natural sub-module: next_pc_calc, combinational mux/adder producing next_pc and pc_plus4, instantiated once.
- FSM, PC, IR, EPC and irq_pending registers stay in pc_fetch_unit.

Test Plan:
- Reset release, imem_ready=1 every REQ cycle, PCSrc=0 -> imem_addr sequence 8000_0000, 8000_0004, 8000_0008; instr_valid pulses every 2nd cycle; instruct matches imem_rdata.
- pc=0000_0010, PCSrc=1, imem16=16'hFFFC, branch_taken=1 -> next fetch 0000_0004; with branch_taken=0 -> 0000_0014.
- pc=0040_0000, PCSrc=2, target26=26'h0000100 -> 0000_0400. Then PCSrc=3 with jr_addr=8000_0123 in user mode -> 0000_0120.
- User mode pc=0000_0020, IRQ pulse for 1 cycle during REQ -> irq_req=1 held. Commit with PCSrc=4 -> pc=8000_0004, epc=0000_0020, irq_req=0.
- imem_ready withheld 5 cycles, then stall=1 for 3 EXEC cycles -> imem_addr and instruct stable; no pc change until stall drops.
- reset asserted in REQ with imem_ready=1 same cycle -> imem_req=0 and pc=8000_0000 immediately; ir stays 0.
